// File: rtl/param_editor_pkg.sv
// Shared constants and types for the parameter editor front end.
// Key indices follow the board's KEY[3:0] wiring.
package param_editor_pkg;

   localparam int KEY_DOWN       = 0;
   localparam int KEY_UP         = 1;
   localparam int KEY_PARAM_NEXT = 2;
   localparam int KEY_FX_NEXT    = 3;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      HOLD,
      REPEAT
   } edit_state_t;

   function automatic int param_default(input int w);
      return 1 << (w - 1);
   endfunction

   localparam int PARAM_DEFAULT = param_default(8);

endpackage

// File: rtl/param_editor_if.sv
// Button/switch inputs and display/effect-chain outputs of the editor.
// The editor sits on the slave side; the board or bench drives the master side.
interface param_editor_if #(
   parameter int FX_COUNT    = 16,
   parameter int PARAM_COUNT = 8,
   parameter int PARAM_W     = 8
);
   localparam int FW = $clog2(FX_COUNT);
   localparam int PW = $clog2(PARAM_COUNT);
   localparam int BW = FX_COUNT * PARAM_COUNT * PARAM_W;

   logic [3:0]         KEY;
   logic [9:0]         SW;
   logic [FW-1:0]      fx_sel;
   logic [PW-1:0]      param_sel;
   logic [PARAM_W-1:0] current_value;
   logic [BW-1:0]      param_flat;
   logic               param_wr;

   modport master (
      output KEY, SW,
      input  fx_sel, param_sel, current_value,
      input  param_flat, param_wr
   );

   modport slave (
      input  KEY, SW,
      output fx_sel, param_sel, current_value,
      output param_flat, param_wr
   );

endinterface

// File: rtl/param_editor_key_conditioner.sv
// One push-button: 2-flop sync, debounce, and press-edge detect.
// Reset assumes the key is held so a key held through reset yields no event.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          cur;
   logic          prev;
   logic          level_q;
   logic [CW-1:0] cnt;

   assign cur   = ~sync[1];
   assign press = level & ~level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b00;
         prev    <= 1'b1;
         cnt     <= '0;
         level   <= 1'b1;
         level_q <= 1'b1;
      end else begin
         sync    <= {sync[0], key};
         prev    <= cur;
         level_q <= level;
         if (cur != prev)
            cnt <= '0;
         else if (cnt != LAST)
            cnt <= cnt + 1'b1;
         else
            level <= cur;
      end
   end

endmodule

// File: rtl/param_editor.sv
// Button-driven editor for the effect parameter bank with
// saturating steps, auto-repeat and restore-to-default.
module param_editor
   import param_editor_pkg::*;
#(
   parameter int FX_COUNT        = 16,
   parameter int PARAM_COUNT     = 8,
   parameter int PARAM_W         = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int COARSE_STEP     = 16
) (
   input logic           clk,
   input logic           rst_n,
   param_editor_if.slave bus
);
   localparam int FW   = $clog2(FX_COUNT);
   localparam int PW   = $clog2(PARAM_COUNT);
   localparam int IW   = FW + PW;
   localparam int N    = FX_COUNT * PARAM_COUNT;
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [PARAM_W-1:0] DEF =
      PARAM_W'(param_default(PARAM_W));
   localparam logic [PARAM_W:0] COARSE = (PARAM_W+1)'(COARSE_STEP);
   localparam logic [PARAM_W:0] FINE   = (PARAM_W+1)'(1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

   logic [3:0] lvl;
   logic [3:0] prs;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_conditioner #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
         .clk   (clk),
         .rst_n (rst_n),
         .key   (bus.KEY[k]),
         .level (lvl[k]),
         .press (prs[k])
      );
   end

   logic nav_unused;
   logic sw_unused;
   assign nav_unused = ^lvl[KEY_FX_NEXT:KEY_PARAM_NEXT];
   assign sw_unused  = ^bus.SW[8:1];

   edit_state_t        state, state_n;
   logic [TW-1:0]      timer, timer_n;
   logic               dir, dir_n;
   logic               block, block_n;
   logic [N*PARAM_W-1:0] bank;
   logic [FW-1:0]      fx;
   logic [PW-1:0]      par;
   logic [IW-1:0]      idx;
   logic [PARAM_W-1:0] old;
   logic [PARAM_W-1:0] stepped;
   logic [PARAM_W-1:0] wr_val;
   logic [PARAM_W-1:0] cur_q;
   logic [PARAM_W:0]   step;
   logic [PARAM_W:0]   sum;
   logic [PARAM_W:0]   diff;
   logic               wr_en;
   logic               wr_q;
   logic               held;
   logic               lock;

   assign idx  = {fx, par};
   assign old  = bank[idx*PARAM_W +: PARAM_W];
   assign lock = bus.SW[9];
   assign held = dir ? lvl[KEY_UP] : lvl[KEY_DOWN];
   assign step = bus.SW[0] ? COARSE : FINE;
   assign sum  = {1'b0, old} + step;
   assign diff = {1'b0, old} - step;

   // Ninth bit is the carry/borrow that triggers saturation.
   always_comb begin
      stepped = old;
      if (dir)
         stepped = sum[PARAM_W] ? '1 : sum[PARAM_W-1:0];
      else
         stepped = diff[PARAM_W] ? '0 : diff[PARAM_W-1:0];
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      dir_n   = dir;
      block_n = block;
      wr_en   = 1'b0;
      wr_val  = old;
      if (block && !lvl[KEY_UP] && !lvl[KEY_DOWN])
         block_n = 1'b0;
      if (lock) begin
         state_n = IDLE;
         timer_n = '0;
      end else if (lvl[KEY_UP] && lvl[KEY_DOWN]) begin
         if (!block) begin
            wr_en   = 1'b1;
            wr_val  = DEF;
            block_n = 1'b1;
         end
         state_n = IDLE;
         timer_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!block && (prs[KEY_UP] || prs[KEY_DOWN])) begin
                  state_n = STEP;
                  dir_n   = prs[KEY_UP];
               end
            end
            STEP: begin
               wr_en   = 1'b1;
               wr_val  = stepped;
               timer_n = '0;
               state_n = HOLD;
            end
            HOLD: begin
               if (!held) begin
                  state_n = IDLE;
               end else if (timer == HOLD_LAST) begin
                  wr_en   = 1'b1;
                  wr_val  = stepped;
                  timer_n = '0;
                  state_n = REPEAT;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            REPEAT: begin
               if (!held) begin
                  state_n = IDLE;
               end else if (timer == REP_LAST) begin
                  wr_en   = 1'b1;
                  wr_val  = stepped;
                  timer_n = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
         dir   <= 1'b0;
         block <= 1'b1;
      end else begin
         state <= state_n;
         timer <= timer_n;
         dir   <= dir_n;
         block <= block_n;
      end
   end

   // Writes target the pre-navigation selection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank  <= {N{DEF}};
         fx    <= '0;
         par   <= '0;
         cur_q <= DEF;
         wr_q  <= 1'b0;
      end else begin
         if (prs[KEY_FX_NEXT])
            fx <= fx + 1'b1;
         if (prs[KEY_PARAM_NEXT])
            par <= par + 1'b1;
         if (wr_en)
            bank[idx*PARAM_W +: PARAM_W] <= wr_val;
         cur_q <= wr_en ? wr_val : old;
         wr_q  <= wr_en && (wr_val != old);
      end
   end

   assign bus.fx_sel        = fx;
   assign bus.param_sel     = par;
   assign bus.current_value = cur_q;
   assign bus.param_flat    = bank;
   assign bus.param_wr      = wr_q;

endmodule

// File: tb/tb_param_editor.sv
// Directed bench for param_editor with short debounce/hold/repeat
// timings; table of button operations plus hand-written corner sequences.
module tb_param_editor;

   localparam int FXN = 16;
   localparam int PN  = 8;
   localparam int W   = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   param_editor_if #(
      .FX_COUNT(FXN), .PARAM_COUNT(PN), .PARAM_W(W)
   ) bus ();

   param_editor #(
      .FX_COUNT(FXN),
      .PARAM_COUNT(PN),
      .PARAM_W(W),
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5),
      .COARSE_STEP(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] keys;
      logic [9:0] sw;
      int         hold;
      int         reps;
      int         fx;
      int         par;
      int         val;
      int         wr;
   } vec_t;

   vec_t tbl[12];

   int n_checks = 0;
   int n_fail   = 0;
   int wr_total = 0;
   int base;
   logic [FXN*PN*W-1:0] exp_flat;

   always @(negedge clk)
      if (rst_n === 1'b1 && bus.param_wr === 1'b1)
         wr_total++;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_sel(input string tag, input int f,
                            input int p, input int v);
      check({tag, "_fx"}, 32'(bus.fx_sel), f);
      check({tag, "_param"}, 32'(bus.param_sel), p);
      check({tag, "_value"}, 32'(bus.current_value), v);
   endtask

   task automatic check_flat(input string tag);
      for (int f = 0; f < FXN; f++)
         for (int p = 0; p < PN; p++)
            check($sformatf("%s_flat_f%0d_p%0d", tag, f, p),
                  32'(bus.param_flat[(f*PN+p)*W +: W]),
                  32'(exp_flat[(f*PN+p)*W +: W]));
   endtask

   task automatic press(input logic [3:0] m, input logic [9:0] sw,
                        input int hold);
      @(negedge clk);
      bus.SW  = sw;
      bus.KEY = ~m;
      repeat (hold) @(negedge clk);
      bus.KEY = 4'hF;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.KEY  = 4'hF;
      bus.SW   = '0;
      exp_flat = {FXN*PN{8'h80}};

      tbl[0]  = '{4'b0010, 10'h000,  10,  1, 0, 0, 129, 1};
      tbl[1]  = '{4'b0100, 10'h000,  10,  1, 0, 1, 128, 0};
      tbl[2]  = '{4'b0010, 10'h001, 100,  1, 0, 1, 255, 8};
      tbl[3]  = '{4'b0010, 10'h001,  10,  1, 0, 1, 255, 0};
      tbl[4]  = '{4'b0100, 10'h000,  10,  1, 0, 2, 128, 0};
      tbl[5]  = '{4'b0001, 10'h001, 100,  1, 0, 2,   0, 8};
      tbl[6]  = '{4'b0010, 10'h000,  10,  5, 0, 2,   5, 5};
      tbl[7]  = '{4'b0001, 10'h001,  10,  1, 0, 2,   0, 1};
      tbl[8]  = '{4'b0001, 10'h000,  10,  1, 0, 2,   0, 0};
      tbl[9]  = '{4'b1000, 10'h000,  10, 17, 1, 2, 128, 0};
      tbl[10] = '{4'b0100, 10'h000,  10,  1, 1, 3, 128, 0};
      tbl[11] = '{4'b0010, 10'h000,  10,  2, 1, 3, 130, 2};

      repeat (3) @(negedge clk);
      check_sel("in_reset", 0, 0, 128);
      check("in_reset_wr", 32'(bus.param_wr), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_sel("idle", 0, 0, 128);
      check("idle_wr_count", wr_total, 0);
      check_flat("idle");

      base = wr_total;
      repeat (6) begin
         bus.KEY[1] = 1'b0;
         @(negedge clk);
         bus.KEY[1] = 1'b1;
         repeat (2) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      check("bounce_value", 32'(bus.current_value), 128);
      check("bounce_wr", wr_total - base, 0);

      for (int i = 0; i < 12; i++) begin
         base = wr_total;
         repeat (tbl[i].reps) press(tbl[i].keys, tbl[i].sw, tbl[i].hold);
         check_sel($sformatf("row%0d", i), tbl[i].fx, tbl[i].par,
                   tbl[i].val);
         check($sformatf("row%0d_wr", i), wr_total - base, tbl[i].wr);
      end

      exp_flat[(0*PN+0)*W +: W] = 8'd129;
      exp_flat[(0*PN+1)*W +: W] = 8'd255;
      exp_flat[(0*PN+2)*W +: W] = 8'd0;
      exp_flat[(1*PN+3)*W +: W] = 8'h82;
      check_flat("edited");

      repeat (4) press(4'b0010, 10'h001, 10);
      repeat (6) press(4'b0010, 10'h000, 10);
      check("build_200", 32'(bus.current_value), 200);
      base = wr_total;
      press(4'b0011, 10'h000, 10);
      check("restore_value", 32'(bus.current_value), 128);
      check("restore_wr", wr_total - base, 1);
      base = wr_total;
      press(4'b0011, 10'h000, 10);
      check("restore_again_wr", wr_total - base, 0);

      base = wr_total;
      press(4'b0010, 10'h200, 10);
      check("lock_value", 32'(bus.current_value), 128);
      check("lock_wr", wr_total - base, 0);
      press(4'b0100, 10'h200, 10);
      check_sel("lock_nav", 1, 4, 128);

      base = wr_total;
      @(negedge clk);
      bus.SW  = 10'h001;
      bus.KEY = ~4'b0010;
      repeat (42) @(negedge clk);
      check("repeat_value", 32'(bus.current_value), 192);
      check("repeat_wr", wr_total - base, 4);
      #2 rst_n = 1'b0;
      #1;
      check_sel("reset_mid", 0, 0, 128);
      check("reset_mid_wr", 32'(bus.param_wr), 0);
      exp_flat = {FXN*PN{8'h80}};
      check_flat("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      base  = wr_total;
      repeat (60) @(negedge clk);
      check("held_wr", wr_total - base, 0);
      check("held_value", 32'(bus.current_value), 128);
      bus.KEY = 4'hF;
      repeat (12) @(negedge clk);
      base = wr_total;
      press(4'b0010, 10'h000, 10);
      check_sel("repress", 0, 0, 129);
      check("repress_wr", wr_total - base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
